ysyx_24080014_lsu: RTL and testbench

Load/store unit directly upstream of the GPR/CSR writeback. It takes a decoded load or store from execute and runs a valid/ready request plus response transaction to data memory. Load data is byte/half aligned and sign/zero extended. It drives the GPR's load-data and mem_ready inputs, so a load's register write is held off until mem_ready pulses.

---
 rtl/ysyx_24080014_pkg.sv | 10 +
 rtl/ysyx_24080014_lsu_align.sv | 38 +++
 rtl/ysyx_24080014_lsu.sv | 104 ++++++++++
 tb/tb_ysyx_24080014_lsu.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_pkg.sv
// ysyx_24080014_pkg: shared funct3 encodings, LSU state encoding and data width.
package ysyx_24080014_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// ysyx_24080014_lsu_align: combinational access checks, store lane shaping and load extension.
//   funct3/addr/store : access size, sign and low address bits of the latched access
//   wdata/rdata       : store source and raw memory read word
//   misalign/illegal  : access fault flags
//   req_wdata/wmask   : lane-replicated store data and byte strobes (zero for loads)
//   ext_rdata         : shifted and sign/zero extended load result
module ysyx_24080014_lsu_align
    import ysyx_24080014_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr,
    input  logic              store,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic              illegal,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wmask,
    output logic [DATA_W-1:0] ext_rdata
);
    logic [DATA_W-1:0] sh;
    always_comb begin
        misalign  = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr != 2'b00);
        illegal   = store ? funct3 > F3_W : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        sh        = rdata >> {addr, 3'b000};
        ext_rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                    funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                    funct3 == F3_BU ? {24'b0, sh[7:0]} :
                    funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
        req_wdata = !store ? '0 :
                    funct3 == F3_B ? {4{wdata[7:0]}} :
                    funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
        req_wmask = !store ? 4'b0000 :
                    funct3 == F3_B ? 4'b0001 << addr :
                    funct3 == F3_H ? (addr[1] ? 4'b1100 : 4'b0011) :
                    funct3 == F3_W ? 4'b1111 : 4'b0000;
    end
endmodule

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu: load/store unit running a valid/ready request + response to data memory.
//   clk/rst_n             : core clock, synchronous active-low reset
//   valid/load/store      : decoded memory instruction from execute, held until mem_ready
//   funct3/addr/wdata     : access size/sign, effective address, store source
//   mem_ready/load_data/fault : one-cycle completion pulse with result to writeback
//   mem_req_*             : request channel (word-aligned address, lane data, strobes)
//   mem_resp_*            : response channel (read data or write ack)
module ysyx_24080014_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] load_data,
    output logic              fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);
    import ysyx_24080014_pkg::*;
    localparam int CW = $clog2(TIMEOUT + 1);
    lsu_state_t state, next;
    logic [ADDR_W-1:0] a_addr;
    logic [2:0]        a_f3;
    logic [DATA_W-1:0] a_wdata;
    logic              a_store;
    logic [CW-1:0]     cnt;
    logic              misalign, illegal, bad, tmo, start;
    logic [DATA_W-1:0] ext_rdata;
    ysyx_24080014_lsu_align u_align (
        .funct3    (a_f3),
        .addr      (a_addr[1:0]),
        .store     (a_store),
        .wdata     (a_wdata),
        .rdata     (mem_resp_rdata),
        .misalign  (misalign),
        .illegal   (illegal),
        .req_wdata (mem_req_wdata),
        .req_wmask (mem_req_wmask),
        .ext_rdata (ext_rdata)
    );
    // The access is checked from latched values during the first REQ cycle,
    // so a faulting access spends that cycle with the request suppressed.
    assign start         = valid && (load || store);
    assign bad           = misalign || illegal;
    assign tmo           = cnt == CW'(TIMEOUT - 1);
    assign mem_ready     = state == DONE;
    assign mem_req_valid = state == REQ && !bad;
    assign mem_req_addr  = {a_addr[ADDR_W-1:2], 2'b00};
    assign mem_req_wen   = a_store;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? REQ : IDLE;
            REQ:     next = (bad || tmo) ? DONE : mem_req_ready ? RESP : REQ;
            RESP:    next = (mem_resp_valid || tmo) ? DONE : RESP;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_addr    <= '0;
            a_f3      <= '0;
            a_wdata   <= '0;
            a_store   <= 1'b0;
            fault     <= 1'b0;
            load_data <= '0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                a_addr  <= addr;
                a_f3    <= funct3;
                a_wdata <= wdata;
                a_store <= store && !load;
                cnt     <= '0;
            end
            if (state == REQ || state == RESP)
                cnt <= cnt + 1'b1;
            // A response arriving on the last allowed cycle still wins over the timeout.
            if (state == RESP && mem_resp_valid) begin
                fault     <= 1'b0;
                load_data <= a_store ? '0 : ext_rdata;
            end else if ((state == REQ && (bad || tmo)) || (state == RESP && tmo)) begin
                fault     <= 1'b1;
                load_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// tb_ysyx_24080014_lsu: directed scoreboard bench for the load/store unit.
module tb_ysyx_24080014_lsu;
    logic        clk = 0, rst_n = 0, valid = 0, load = 0, store = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        mem_ready, fault, mem_req_valid, mem_req_wen;
    logic [31:0] load_data, mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_req_ready = 0, mem_resp_valid = 0;
    logic [31:0] mem_resp_rdata = 0;
    typedef struct {logic [31:0] ld; logic f; logic chk_ld;} exp_t;
    exp_t sb[$];
    int total = 0, passed = 0, fails = 0;
    always #5 clk = ~clk;
    ysyx_24080014_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .load(load), .store(store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_ready(mem_ready), .load_data(load_data), .fault(fault),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic outs_zero(input string tag);
        chk({tag, " mem_ready"}, 32'(mem_ready), 0);
        chk({tag, " fault"}, 32'(fault), 0);
        chk({tag, " load_data"}, load_data, 0);
        chk({tag, " req_valid"}, 32'(mem_req_valid), 0);
        chk({tag, " req_wen"}, 32'(mem_req_wen), 0);
        chk({tag, " req_addr"}, mem_req_addr, 0);
        chk({tag, " req_wdata"}, mem_req_wdata, 0);
        chk({tag, " req_wmask"}, 32'(mem_req_wmask), 0);
    endtask
    task automatic txn(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int rdy_dly,
                       input int resp_dly, input logic respond, input logic [31:0] rd,
                       input logic [31:0] exp_ld, input logic exp_f, input int exp_lat,
                       input int exp_nreq, input logic [31:0] exp_wd, input logic [3:0] exp_wm);
        int acc = -1, nreq = 0, lat = -1;
        exp_t got;
        sb.push_back('{exp_ld, exp_f, ld});
        @(negedge clk);
        valid = 1; load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            mem_req_ready = 0;
            mem_resp_valid = 0;
            if (mem_ready) begin
                lat = k;
                valid = 0; load = 0; store = 0;
                chk({tag, " sb_size"}, sb.size(), 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    if (got.chk_ld) chk({tag, " load_data"}, load_data, got.ld);
                    chk({tag, " fault"}, 32'(fault), 32'(got.f));
                end
            end else begin
                if (acc >= 0 && respond && k == acc + 1 + resp_dly) begin
                    mem_resp_valid = 1;
                    mem_resp_rdata = rd;
                end
                if (mem_req_valid) begin
                    nreq++;
                    chk({tag, " req_addr"}, mem_req_addr, {a[31:2], 2'b00});
                    chk({tag, " req_wen"}, 32'(mem_req_wen), 32'(st && !ld));
                    chk({tag, " req_wmask"}, 32'(mem_req_wmask), 32'(exp_wm));
                    if (st && !ld) chk({tag, " req_wdata"}, mem_req_wdata, exp_wd);
                    if (acc < 0 && nreq > rdy_dly) begin
                        mem_req_ready = 1;
                        acc = k;
                    end
                end
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " nreq"}, nreq, exp_nreq);
        @(negedge clk);
        chk({tag, " pulse_one"}, 32'(mem_ready), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        outs_zero("reset");
        rst_n = 1;
        txn("lw", 1, 0, 3'b010, 32'h80000004, 0, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 1, 0, 4'b0000);
        txn("lb", 1, 0, 3'b000, 32'h80000003, 0, 0, 0, 1, 32'h80FF1234, 32'hFFFFFF80, 0, 3, 1, 0, 4'b0000);
        txn("lbu", 1, 0, 3'b100, 32'h80000003, 0, 0, 0, 1, 32'h80FF1234, 32'h00000080, 0, 3, 1, 0, 4'b0000);
        txn("lhu", 1, 0, 3'b101, 32'h80000002, 0, 0, 0, 1, 32'h80FF1234, 32'h000080FF, 0, 3, 1, 0, 4'b0000);
        txn("lh", 1, 0, 3'b001, 32'h80000002, 0, 0, 1, 1, 32'h80FF1234, 32'hFFFF80FF, 0, 4, 1, 0, 4'b0000);
        txn("lb1", 1, 0, 3'b000, 32'h80000001, 0, 1, 0, 1, 32'h80FF1234, 32'h00000012, 0, 4, 2, 0, 4'b0000);
        txn("ld_st", 1, 1, 3'b010, 32'h80000008, 32'h55555555, 0, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 0, 3, 1, 0, 4'b0000);
        txn("sh", 0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 3, 0, 1, 0, 0, 0, 6, 4, 32'hABCDABCD, 4'b1100);
        txn("sb", 0, 1, 3'b000, 32'h80000001, 32'h000000A5, 0, 0, 1, 0, 0, 0, 3, 1, 32'hA5A5A5A5, 4'b0010);
        txn("sw", 0, 1, 3'b010, 32'h80000008, 32'h11223344, 0, 0, 1, 0, 0, 0, 3, 1, 32'h11223344, 4'b1111);
        txn("lw_mis", 1, 0, 3'b010, 32'h80000002, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 4'b0000);
        txn("lh_mis", 1, 0, 3'b001, 32'h80000001, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 4'b0000);
        txn("ld_ill", 1, 0, 3'b011, 32'h80000000, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 4'b0000);
        txn("st_ill", 0, 1, 3'b100, 32'h80000000, 32'h1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 4'b0000);
        txn("tmo_req", 1, 0, 3'b010, 32'h80000004, 0, 100, 0, 0, 0, 0, 1, 9, 8, 0, 4'b0000);
        txn("tmo_resp", 1, 0, 3'b010, 32'h80000004, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 4'b0000);
        mem_resp_valid = 1;
        mem_resp_rdata = 32'h12345678;
        @(negedge clk);
        chk("stray mem_ready", 32'(mem_ready), 0);
        chk("stray req_valid", 32'(mem_req_valid), 0);
        mem_resp_valid = 0;
        @(negedge clk);
        chk("stray mem_ready2", 32'(mem_ready), 0);
        @(negedge clk);
        valid = 1; store = 1; funct3 = 3'b010; addr = 32'h80000010; wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst req_valid", 32'(mem_req_valid), 1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; valid = 0; store = 0; rst_n = 0;
        @(negedge clk);
        outs_zero("midrst");
        rst_n = 1;
        mem_resp_valid = 1;
        @(negedge clk);
        mem_resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst no_ready", 32'(mem_ready), 0);
            @(negedge clk);
        end
        txn("lw_post", 1, 0, 3'b010, 32'h80000020, 0, 0, 0, 1, 32'hA5A55A5A, 32'hA5A55A5A, 0, 3, 1, 0, 4'b0000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
